avalon_mem_responder: RTL

//  Memory-side end of the CPU data/instruction bus: services the read, write,

---
 rtl/avalon_mem_responder_if.sv | 33 +++
 rtl/avalon_mem_responder.sv | 132 +++++++++++++
 2 files changed

// File: rtl/avalon_mem_responder_if.sv
// ----------------------------------------------------------------------------
// avalon_mem_responder_if
//   Avalon-style memory bus between a CPU control path (master) and the
//   memory responder (slave).
//   address      32  byte address from the master
//   read         1   read request
//   write        1   write request
//   byteenable   4   write lane enables, bit0 = writedata[7:0]
//   writedata    32  write data
//   waitrequest  1   1 = request not yet accepted, master holds inputs
//   readdata     32  read word, valid in the ack cycle of a read
//   protocol_err 1   sticky protocol-violation flag
// ----------------------------------------------------------------------------
interface avalon_mem_responder_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        protocol_err;

    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata, protocol_err
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata, protocol_err
    );
endinterface

// File: rtl/avalon_mem_responder.sv
// ----------------------------------------------------------------------------
// avalon_mem_responder
//   Word-organised RAM slave with a programmable stall of WAIT_CYCLES cycles
//   per transfer and Avalon-style waitrequest. Every transfer walks
//   IDLE -> WAIT -> ACK -> IDLE (IDLE -> ACK when WAIT_CYCLES = 0).
//   clk      in  system clock, rising edge
//   reset_n  in  asynchronous active-low reset (RAM contents are kept)
//   bus      slave side of avalon_mem_responder_if
// ----------------------------------------------------------------------------
module avalon_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    avalon_mem_responder_if.slave   bus
);

    localparam int         DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    logic [31:0]           mem [DEPTH];

    state_t                state;
    logic [3:0]            count;
    logic [ADDR_WIDTH-1:0] lat_index;
    logic [31:0]           lat_address;
    logic [1:0]            lat_rw;       // raw {read, write} seen at request
    logic                  lat_is_write; // write-only request; read wins a clash
    logic [3:0]            lat_be;
    logic [31:0]           lat_data;
    logic [31:0]           readdata_q;
    logic                  err_q;

    logic                  request;
    logic [ADDR_WIDTH-1:0] req_index;

    assign request   = bus.read | bus.write;
    // Upper address bits are dropped so accesses wrap modulo the depth.
    assign req_index = bus.address[ADDR_WIDTH+1:2];

    // In IDLE the stall follows the request combinationally so that the very
    // first request cycle is already held off.
    assign bus.waitrequest  = ~reset_n
                            | ((state == ST_IDLE) ? request : (state == ST_WAIT));
    assign bus.readdata     = readdata_q;
    assign bus.protocol_err = err_q;

    // NOTE: sequential state is assigned with <= so every register samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            count        <= '0;
            lat_index    <= '0;
            lat_address  <= '0;
            lat_rw       <= '0;
            lat_is_write <= 1'b0;
            lat_be       <= '0;
            lat_data     <= '0;
            readdata_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (request) begin
                        lat_index    <= req_index;
                        lat_address  <= bus.address;
                        lat_rw       <= {bus.read, bus.write};
                        lat_is_write <= bus.write & ~bus.read;
                        lat_be       <= bus.byteenable;
                        lat_data     <= bus.writedata;
                        count        <= WAIT_INIT;
                        if ((bus.read & bus.write) || (bus.address[1:0] != 2'b00))
                            err_q <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_ACK;
                            // No WAIT cycle exists, so the read word is fetched now.
                            if (bus.read)
                                readdata_q <= mem[req_index];
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    if (!request) begin
                        // Master gave up: abandon without touching the RAM.
                        state <= ST_IDLE;
                        err_q <= 1'b1;
                    end else begin
                        count <= count - 4'd1;
                        if ((bus.address != lat_address) || ({bus.read, bus.write} != lat_rw))
                            err_q <= 1'b1;
                        if (count == 4'd1) begin
                            state <= ST_ACK;
                            if (!lat_is_write)
                                readdata_q <= mem[lat_index];
                        end
                    end
                end

                ST_ACK: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: the RAM array has no reset; contents survive reset_n, and an
    // aborted transfer never reaches ACK so it never commits.
    always_ff @(posedge clk) begin
        if (state == ST_ACK && lat_is_write) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (lat_be[lane])
                    mem[lat_index][8*lane +: 8] <= lat_data[8*lane +: 8];
            end
        end
    end

endmodule
